// File: rtl/output_port_arbiter.sv
// -----------------------------------------------------------------------------
// output_port_arbiter
//   Wormhole arbiter for one router output port. Grants one requesting input
//   round-robin on a head flit, then holds the grant until that input's tail
//   flit has transferred. Every flit is metered against a downstream credit
//   counter, so the output buffer can never overflow.
//
// Ports
//   clk          in   clock, rising edge
//   arst         in   synchronous active-high reset
//   req_i        in   [N_INPUTS]  input i requests this output
//   head_i       in   [N_INPUTS]  flit of input i is a head flit
//   tail_i       in   [N_INPUTS]  flit of input i is a tail flit
//   ready_o      out  [N_INPUTS]  one-hot/zero; input i moves when req_i[i]&ready_o[i]
//   sel_o        out  [SEL_W]     index of the granted input (crossbar select)
//   valid_o      out  flit leaves on the output this cycle
//   credit_ret_i in   downstream freed one slot
//   locked_o     out  packet in progress
//   wdog_err_o   out  sticky lock watchdog error
//
// Build options
//   ARB_WDOG_EN    adds the lock watchdog; otherwise wdog_err_o is tied low.
//   NO_ASSERTIONS  drops the protocol checker instance.
// -----------------------------------------------------------------------------
module output_port_arbiter #(
    parameter int N_INPUTS    = 5,
    parameter int CREDITS     = 4,
    parameter int WDOG_CYCLES = 256,
    localparam int SEL_W      = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1,
    localparam int CRED_W     = $clog2(CREDITS + 1)
) (
    input  logic                clk,
    input  logic                arst,
    input  logic [N_INPUTS-1:0] req_i,
    input  logic [N_INPUTS-1:0] head_i,
    input  logic [N_INPUTS-1:0] tail_i,
    output logic [N_INPUTS-1:0] ready_o,
    output logic [SEL_W-1:0]    sel_o,
    output logic                valid_o,
    input  logic                credit_ret_i,
    output logic                locked_o,
    output logic                wdog_err_o
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]          state_r;
    logic [SEL_W-1:0]    rr_ptr_r;
    logic [SEL_W-1:0]    sel_r;
    logic [CRED_W-1:0]   credits_r;

    logic [N_INPUTS-1:0] eligible_s;
    logic [N_INPUTS-1:0] grant_s;
    logic [SEL_W-1:0]    win_s;
    logic                found_s;
    logic                xfer_s;
    logic                last_s;
    int                  idx_s;

    // Round-robin successor, wrapping N_INPUTS-1 back to 0.
    function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] i);
        if (i == SEL_W'(N_INPUTS - 1)) begin
            next_idx = '0;
        end else begin
            next_idx = i + 1'b1;
        end
    endfunction

    // Zero-cycle arbitration: pick the grant from state, credits and requests.
    // credit_ret_i is deliberately absent so a returned credit is only usable
    // on the following cycle.
    always_comb begin
        eligible_s = req_i & head_i;
        grant_s    = '0;
        win_s      = sel_r;
        found_s    = 1'b0;
        idx_s      = 0;
        if (arst) begin
            grant_s = '0;
        end else if (state_r == ST_IDLE) begin
            if (credits_r != '0) begin
                for (int k = 0; k < N_INPUTS; k++) begin
                    idx_s = int'(rr_ptr_r) + k;
                    if (idx_s >= N_INPUTS) begin
                        idx_s = idx_s - N_INPUTS;
                    end else begin
                        idx_s = idx_s;
                    end
                    if (!found_s && eligible_s[idx_s]) begin
                        found_s = 1'b1;
                        win_s   = SEL_W'(idx_s);
                    end else begin
                        found_s = found_s;
                    end
                end
                if (found_s) begin
                    grant_s[win_s] = 1'b1;
                end else begin
                    grant_s = '0;
                end
            end else begin
                grant_s = '0;
            end
        end else begin
            // Locked: only the owner may move, and only with a credit in hand.
            if (credits_r != '0) begin
                grant_s[sel_r] = 1'b1;
            end else begin
                grant_s = '0;
            end
        end
    end

    assign xfer_s   = |(req_i & grant_s);
    assign last_s   = xfer_s & tail_i[win_s];
    assign ready_o  = grant_s;
    assign sel_o    = win_s;
    assign valid_o  = xfer_s;
    assign locked_o = (state_r == ST_LOCKED);

    // Packet lock state, round-robin pointer and held select.
    always_ff @(posedge clk) begin
        if (arst) begin
            state_r  <= ST_IDLE;
            rr_ptr_r <= '0;
            sel_r    <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (xfer_s) begin
                        sel_r <= win_s;
                        if (last_s) begin
                            rr_ptr_r <= next_idx(win_s);
                        end else begin
                            state_r <= ST_LOCKED;
                        end
                    end
                end
                ST_LOCKED: begin
                    // A head flit on the owner mid-packet is treated as body.
                    if (last_s) begin
                        state_r  <= ST_IDLE;
                        rr_ptr_r <= next_idx(sel_r);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Downstream credit counter; a return at full count is dropped.
    always_ff @(posedge clk) begin
        if (arst) begin
            credits_r <= CRED_W'(CREDITS);
        end else begin
            case ({xfer_s, credit_ret_i})
                2'b10: credits_r <= credits_r - 1'b1;
                2'b01: begin
                    if (credits_r != CRED_W'(CREDITS)) begin
                        credits_r <= credits_r + 1'b1;
                    end
                end
                default: credits_r <= credits_r;
            endcase
        end
    end

`ifdef ARB_WDOG_EN
    localparam int WD_W = $clog2(WDOG_CYCLES + 1);

    logic [WD_W-1:0] wdog_cnt_r;
    logic            wdog_err_r;

    // Lock watchdog: counts locked cycles without a flit moving. Entering and
    // leaving LOCKED always coincide with a transfer, so clearing on transfer
    // covers both.
    always_ff @(posedge clk) begin
        if (arst) begin
            wdog_cnt_r <= '0;
            wdog_err_r <= 1'b0;
        end else if (xfer_s) begin
            wdog_cnt_r <= '0;
        end else if (state_r == ST_LOCKED) begin
            if (wdog_cnt_r != WD_W'(WDOG_CYCLES)) begin
                wdog_cnt_r <= wdog_cnt_r + 1'b1;
                if (wdog_cnt_r == WD_W'(WDOG_CYCLES - 1)) begin
                    wdog_err_r <= 1'b1;
                end
            end
        end else begin
            wdog_cnt_r <= '0;
        end
    end

    assign wdog_err_o = wdog_err_r;
`else
    assign wdog_err_o = 1'b0;
`endif

`ifndef NO_ASSERTIONS
    output_port_arbiter_checker #(
        .N_INPUTS (N_INPUTS),
        .CREDITS  (CREDITS)
    ) u_checker (
        .clk        (clk),
        .arst       (arst),
        .ready      (grant_s),
        .valid      (xfer_s),
        .credits    (credits_r),
        .credit_ret (credit_ret_i),
        .locked     (locked_o),
        .head       (head_i),
        .sel        (sel_r)
    );
`endif

endmodule

// -----------------------------------------------------------------------------
// output_port_arbiter_checker
//   Invariant checks for the arbiter. Internal invariants are errors; upstream
//   protocol violations (extra credit, head mid-packet) are warnings because
//   the arbiter tolerates them.
// -----------------------------------------------------------------------------
module output_port_arbiter_checker #(
    parameter int N_INPUTS    = 5,
    parameter int CREDITS     = 4,
    localparam int SEL_W      = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1,
    localparam int CRED_W     = $clog2(CREDITS + 1)
) (
    input logic                clk,
    input logic                arst,
    input logic [N_INPUTS-1:0] ready,
    input logic                valid,
    input logic [CRED_W-1:0]   credits,
    input logic                credit_ret,
    input logic                locked,
    input logic [N_INPUTS-1:0] head,
    input logic [SEL_W-1:0]    sel
);

    // Per-cycle invariant and protocol checks.
    always @(posedge clk) begin
        if (!arst) begin
            assert ($onehot0(ready)) else $error("arbiter: ready not one-hot");
            if (valid) begin
                assert (credits != '0) else $error("arbiter: transfer with no credit");
            end
            if (credit_ret && !valid) begin
                assert (credits != CRED_W'(CREDITS))
                    else $warning("arbiter: credit return at full count ignored");
            end
            if (locked && valid) begin
                assert (!head[sel]) else $warning("arbiter: head flit on locked input");
            end
        end
    end

endmodule

// File: tb/tb_output_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_output_port_arbiter
//   Directed bench for output_port_arbiter (N_INPUTS=5, CREDITS=4,
//   WDOG_CYCLES=8). Inputs change 1 ns after the rising edge and outputs are
//   checked 1 ns later, well before the next edge.
// -----------------------------------------------------------------------------
module tb_output_port_arbiter;

    logic       clk = 1'b0;
    logic       arst;
    logic [4:0] req_i;
    logic [4:0] head_i;
    logic [4:0] tail_i;
    logic [4:0] ready_o;
    logic [2:0] sel_o;
    logic       valid_o;
    logic       credit_ret_i;
    logic       locked_o;
    logic       wdog_err_o;

    int checks = 0;
    int errors = 0;

    output_port_arbiter #(
        .N_INPUTS    (5),
        .CREDITS     (4),
        .WDOG_CYCLES (8)
    ) dut (
        .clk          (clk),
        .arst         (arst),
        .req_i        (req_i),
        .head_i       (head_i),
        .tail_i       (tail_i),
        .ready_o      (ready_o),
        .sel_o        (sel_o),
        .valid_o      (valid_o),
        .credit_ret_i (credit_ret_i),
        .locked_o     (locked_o),
        .wdog_err_o   (wdog_err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
            else begin
                errors++;
                $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
            end
    endtask

    // Advance to the next cycle, apply inputs, let combinational outputs settle.
    task automatic cyc(input logic rst, input logic [4:0] rq, input logic [4:0] hd,
                       input logic [4:0] tl, input logic cr);
        @(posedge clk);
        #1;
        arst         = rst;
        req_i        = rq;
        head_i       = hd;
        tail_i       = tl;
        credit_ret_i = cr;
        #1;
    endtask

    // Expect a grant (or none) on this cycle.
    task automatic exp_grant(input string tag, input logic [4:0] rdy, input logic vld,
                             input logic [2:0] sel, input logic lck);
        chk({tag, "_ready"},  32'(ready_o),  32'(rdy));
        chk({tag, "_valid"},  32'(valid_o),  32'(vld));
        chk({tag, "_sel"},    32'(sel_o),    32'(sel));
        chk({tag, "_locked"}, 32'(locked_o), 32'(lck));
    endtask

    initial begin
        arst = 1'b1; req_i = 5'b0; head_i = 5'b0; tail_i = 5'b0; credit_ret_i = 1'b0;

        // Reset: requests during reset must not be granted.
        cyc(1'b1, 5'b11111, 5'b11111, 5'b11111, 1'b0);
        chk("rst_ready", 32'(ready_o), 32'd0);
        chk("rst_valid", 32'(valid_o), 32'd0);
        cyc(1'b0, 5'b00000, 5'b00000, 5'b00000, 1'b0);
        exp_grant("rst_out", 5'b00000, 1'b0, 3'd0, 1'b0);
        chk("rst_wdog", 32'(wdog_err_o), 32'd0);

        // Round-robin among 0,2,4 with single-flit packets, credit returned
        // every cycle so the count stays at 4.
        cyc(1'b0, 5'b10101, 5'b10101, 5'b10101, 1'b1);
        exp_grant("rr0", 5'b00001, 1'b1, 3'd0, 1'b0);
        cyc(1'b0, 5'b10101, 5'b10101, 5'b10101, 1'b1);
        exp_grant("rr1", 5'b00100, 1'b1, 3'd2, 1'b0);
        cyc(1'b0, 5'b10101, 5'b10101, 5'b10101, 1'b1);
        exp_grant("rr2", 5'b10000, 1'b1, 3'd4, 1'b0);
        cyc(1'b0, 5'b10101, 5'b10101, 5'b10101, 1'b1);
        exp_grant("rr3_wrap", 5'b00001, 1'b1, 3'd0, 1'b0);
        cyc(1'b0, 5'b10101, 5'b10101, 5'b10101, 1'b1);
        exp_grant("rr4", 5'b00100, 1'b1, 3'd2, 1'b0);
        // rr_ptr now 3, credits 4

        // Wormhole lock: input1 H,B,T; input3 asks from the body cycle on.
        cyc(1'b0, 5'b00010, 5'b00010, 5'b00000, 1'b0);
        exp_grant("wh_head", 5'b00010, 1'b1, 3'd1, 1'b0);
        cyc(1'b0, 5'b01010, 5'b01000, 5'b00000, 1'b0);
        exp_grant("wh_body", 5'b00010, 1'b1, 3'd1, 1'b1);
        cyc(1'b0, 5'b01010, 5'b01000, 5'b00010, 1'b0);
        exp_grant("wh_tail", 5'b00010, 1'b1, 3'd1, 1'b1);
        cyc(1'b0, 5'b01000, 5'b01000, 5'b01000, 1'b0);
        exp_grant("wh_next", 5'b01000, 1'b1, 3'd3, 1'b0);
        // credits now 0, rr_ptr 4

        // Credits exhausted in IDLE; a return this cycle is not visible yet.
        cyc(1'b0, 5'b00001, 5'b00001, 5'b00001, 1'b1);
        chk("cr0_ready", 32'(ready_o), 32'd0);
        chk("cr0_valid", 32'(valid_o), 32'd0);
        cyc(1'b0, 5'b00001, 5'b00001, 5'b00001, 1'b0);
        exp_grant("cr1_grant", 5'b00001, 1'b1, 3'd0, 1'b0);
        // credits 0, rr_ptr 1; refill to 4, then one extra return (ignored)
        cyc(1'b0, 5'b00000, 5'b00000, 5'b00000, 1'b1);
        cyc(1'b0, 5'b00000, 5'b00000, 5'b00000, 1'b1);
        cyc(1'b0, 5'b00000, 5'b00000, 5'b00000, 1'b1);
        cyc(1'b0, 5'b00000, 5'b00000, 5'b00000, 1'b1);
        cyc(1'b0, 5'b00000, 5'b00000, 5'b00000, 1'b1);

        // Six-flit packet from input2: four flits, then a stall.
        cyc(1'b0, 5'b00100, 5'b00100, 5'b00000, 1'b0);
        exp_grant("c6_f1", 5'b00100, 1'b1, 3'd2, 1'b0);
        cyc(1'b0, 5'b00100, 5'b00000, 5'b00000, 1'b0);
        chk("c6_f2_valid", 32'(valid_o), 32'd1);
        cyc(1'b0, 5'b00100, 5'b00000, 5'b00000, 1'b0);
        chk("c6_f3_valid", 32'(valid_o), 32'd1);
        cyc(1'b0, 5'b00100, 5'b00000, 5'b00000, 1'b0);
        exp_grant("c6_f4", 5'b00100, 1'b1, 3'd2, 1'b1);
        cyc(1'b0, 5'b00100, 5'b00000, 5'b00000, 1'b0);
        exp_grant("c6_stall", 5'b00000, 1'b0, 3'd2, 1'b1);
        cyc(1'b0, 5'b00100, 5'b00000, 5'b00000, 1'b1);
        chk("c6_ret_same_cyc", 32'(ready_o), 32'd0);
        cyc(1'b0, 5'b00100, 5'b00000, 5'b00000, 1'b0);
        exp_grant("c6_f5", 5'b00100, 1'b1, 3'd2, 1'b1);
        cyc(1'b0, 5'b00100, 5'b00000, 5'b00000, 1'b1);
        chk("c6_stall2", 32'(ready_o), 32'd0);
        cyc(1'b0, 5'b00100, 5'b00000, 5'b00100, 1'b1);
        exp_grant("c6_f6_tail", 5'b00100, 1'b1, 3'd2, 1'b1);
        // credits 1 (transfer+return), rr_ptr 3
        cyc(1'b0, 5'b00100, 5'b00100, 5'b00100, 1'b1);
        exp_grant("cr_simul", 5'b00100, 1'b1, 3'd2, 1'b0);
        cyc(1'b0, 5'b00100, 5'b00100, 5'b00100, 1'b0);
        exp_grant("cr_kept", 5'b00100, 1'b1, 3'd2, 1'b0);
        cyc(1'b0, 5'b00100, 5'b00100, 5'b00100, 1'b0);
        chk("cr_empty", 32'(ready_o), 32'd0);
        chk("wdog_off_or_low", 32'(wdog_err_o), 32'd0);

        // Reset mid-packet restores credits and drops the lock.
        cyc(1'b1, 5'b11111, 5'b11111, 5'b00000, 1'b0);
        chk("rst2_ready", 32'(ready_o), 32'd0);
        cyc(1'b0, 5'b00001, 5'b00001, 5'b00000, 1'b0);
        exp_grant("rl_head", 5'b00001, 1'b1, 3'd0, 1'b0);
        cyc(1'b1, 5'b00001, 5'b00000, 5'b00000, 1'b0);
        chk("rl_locked_in_rst", 32'(locked_o), 32'd1);
        chk("rl_no_xfer", 32'(valid_o), 32'd0);
        cyc(1'b0, 5'b00000, 5'b00000, 5'b00000, 1'b0);
        exp_grant("rl_after", 5'b00000, 1'b0, 3'd0, 1'b0);

        // Requests without head in IDLE are never granted.
        cyc(1'b0, 5'b00010, 5'b00000, 5'b00000, 1'b0);
        exp_grant("nohead0", 5'b00000, 1'b0, 3'd0, 1'b0);
        cyc(1'b0, 5'b00010, 5'b00000, 5'b00010, 1'b0);
        exp_grant("nohead1", 5'b00000, 1'b0, 3'd0, 1'b0);

`ifdef ARB_WDOG_EN
        // Lock input2, then starve it for 8 cycles.
        cyc(1'b0, 5'b00100, 5'b00100, 5'b00000, 1'b0);
        exp_grant("wd_head", 5'b00100, 1'b1, 3'd2, 1'b0);
        for (int i = 0; i < 7; i++) begin
            cyc(1'b0, 5'b00000, 5'b00000, 5'b00000, 1'b0);
        end
        cyc(1'b0, 5'b00000, 5'b00000, 5'b00000, 1'b0);
        chk("wd_before", 32'(wdog_err_o), 32'd0);
        cyc(1'b0, 5'b00100, 5'b00000, 5'b00100, 1'b0);
        chk("wd_set", 32'(wdog_err_o), 32'd1);
        chk("wd_lock_kept", 32'(locked_o), 32'd1);
        cyc(1'b0, 5'b00000, 5'b00000, 5'b00000, 1'b0);
        chk("wd_sticky", 32'(wdog_err_o), 32'd1);
        chk("wd_unlocked", 32'(locked_o), 32'd0);
`else
        cyc(1'b0, 5'b00000, 5'b00000, 5'b00000, 1'b0);
        chk("wdog_tied_low", 32'(wdog_err_o), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
